// File: rtl/cwe1234_debug_unlock_ctrl.sv
// Debug-unlock authentication controller: emits the boot-time Lock pulse and
// gates debug write access behind a fuse-key compare with attempt-limited lockout.
module cwe1234_debug_unlock_ctrl #(
  parameter int KEY_W          = 16,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int UNLOCK_TIMEOUT = 4096,
  localparam int CW = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             boot_done,
  input  logic [KEY_W-1:0] fuse_key,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_ready,
  input  logic             relock,
  output logic             Lock,
  output logic             debug_unlocked,
  output logic [CW-1:0]    fail_cnt,
  output logic             locked_out,
  output logic [7:0]       lockout_events
);

  localparam int TW = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCKOUT_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] FAIL_LAST    = CW'(MAX_ATTEMPTS - 1);
  localparam logic [CW-1:0] FAIL_MAX     = CW'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {IDLE, CHECK, UNLOCKED, LOCKOUT} state_t;

  state_t           state;
  logic [KEY_W-1:0] key_q;
  logic [TW-1:0]    unlock_cnt;
  logic [LW-1:0]    lockout_cnt;
  logic             boot_done_q;
  logic             key_match;

  // An unprogrammed (all-zero) fuse must never authenticate anything.
  assign key_match = (key_q == fuse_key) && (fuse_key != '0);

  always_ff @(posedge Clk) begin
    if (reset) begin
      boot_done_q <= 1'b0;
      Lock        <= 1'b0;
    end else begin
      boot_done_q <= boot_done;
      Lock        <= boot_done & ~boot_done_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state          <= IDLE;
      key_q          <= '0;
      unlock_cnt     <= '0;
      lockout_cnt    <= '0;
      key_ready      <= 1'b0;
      debug_unlocked <= 1'b0;
      fail_cnt       <= '0;
      locked_out     <= 1'b0;
      lockout_events <= '0;
    end else begin
      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          if (key_valid && key_ready) begin
            key_q     <= key_in;
            state     <= CHECK;
            key_ready <= 1'b0;
          end
        end

        CHECK: begin
          if (key_match) begin
            state          <= UNLOCKED;
            fail_cnt       <= '0;
            debug_unlocked <= 1'b1;
            unlock_cnt     <= '0;
          end else if (fail_cnt == FAIL_LAST) begin
            state       <= LOCKOUT;
            fail_cnt    <= FAIL_MAX;
            locked_out  <= 1'b1;
            lockout_cnt <= '0;
            if (lockout_events != 8'hFF)
              lockout_events <= lockout_events + 8'd1;
          end else begin
            state     <= IDLE;
            fail_cnt  <= fail_cnt + 1'b1;
            key_ready <= 1'b1;
          end
        end

        // Exiting on the last count keeps access open for exactly UNLOCK_TIMEOUT cycles.
        UNLOCKED: begin
          if (relock || (unlock_cnt == UNLOCK_LAST)) begin
            state          <= IDLE;
            debug_unlocked <= 1'b0;
            key_ready      <= 1'b1;
            unlock_cnt     <= '0;
          end else begin
            unlock_cnt <= unlock_cnt + 1'b1;
          end
        end

        LOCKOUT: begin
          if (lockout_cnt == LOCKOUT_LAST) begin
            state       <= IDLE;
            locked_out  <= 1'b0;
            fail_cnt    <= '0;
            key_ready   <= 1'b1;
            lockout_cnt <= '0;
          end else begin
            lockout_cnt <= lockout_cnt + 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          key_ready      <= 1'b0;
          debug_unlocked <= 1'b0;
          locked_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cwe1234_debug_unlock_ctrl.sv
// Directed bench for cwe1234_debug_unlock_ctrl: boot Lock pulse, unlock/timeout,
// lockout after repeated failures, relock, reset abort and all-zero fuse.
module tb_cwe1234_debug_unlock_ctrl;

  localparam int KEY_W = 16;
  localparam int CW    = 2;
  localparam logic [KEY_W-1:0] GOOD_KEY = 16'hA5C3;
  localparam logic [KEY_W-1:0] BAD_KEY  = 16'h0001;

  logic             Clk = 1'b0;
  logic             reset;
  logic             boot_done;
  logic [KEY_W-1:0] fuse_key;
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             key_ready;
  logic             relock;
  logic             Lock;
  logic             debug_unlocked;
  logic [CW-1:0]    fail_cnt;
  logic             locked_out;
  logic [7:0]       lockout_events;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  cwe1234_debug_unlock_ctrl #(
    .KEY_W(KEY_W),
    .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(1024),
    .UNLOCK_TIMEOUT(4096)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .boot_done(boot_done),
    .fuse_key(fuse_key),
    .key_valid(key_valid),
    .key_in(key_in),
    .key_ready(key_ready),
    .relock(relock),
    .Lock(Lock),
    .debug_unlocked(debug_unlocked),
    .fail_cnt(fail_cnt),
    .locked_out(locked_out),
    .lockout_events(lockout_events)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [KEY_W-1:0] key, input logic rl);
    key_valid = valid;
    key_in    = key;
    relock    = rl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic kr, input logic lk, input logic du,
                          input logic [CW-1:0] fc, input logic lo, input logic [7:0] ev);
    checkOutput({tag, "/key_ready"}, 32'(key_ready), 32'(kr));
    checkOutput({tag, "/Lock"}, 32'(Lock), 32'(lk));
    checkOutput({tag, "/debug_unlocked"}, 32'(debug_unlocked), 32'(du));
    checkOutput({tag, "/fail_cnt"}, 32'(fail_cnt), 32'(fc));
    checkOutput({tag, "/locked_out"}, 32'(locked_out), 32'(lo));
    checkOutput({tag, "/lockout_events"}, 32'(lockout_events), 32'(ev));
  endtask

  // Accept edge followed by the single CHECK edge.
  task automatic sendKey(input logic [KEY_W-1:0] key);
    applyStimulus(1'b1, key, 1'b0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0);
    step(1);
  endtask

  initial begin
    reset     = 1'b1;
    boot_done = 1'b0;
    fuse_key  = GOOD_KEY;
    applyStimulus(1'b0, '0, 1'b0);
    step(2);
    checkAll("reset", 0, 0, 0, 0, 0, 8'd0);
    reset = 1'b0;
    step(1);
    checkAll("release", 1, 0, 0, 0, 0, 8'd0);

    // Boot completion: single Lock pulse, no repeat while level stays high
    boot_done = 1'b1;
    step(1);
    checkAll("lock_pulse", 1, 1, 0, 0, 0, 8'd0);
    step(1);
    checkOutput("lock_drop", 32'(Lock), 32'd0);
    step(1);
    checkOutput("lock_hold", 32'(Lock), 32'd0);

    // Correct key: unlock on 2nd edge, held exactly 4096 cycles
    applyStimulus(1'b1, GOOD_KEY, 1'b0);
    step(1);
    checkOutput("accept/key_ready", 32'(key_ready), 32'd0);
    checkOutput("accept/debug_unlocked", 32'(debug_unlocked), 32'd0);
    applyStimulus(1'b1, BAD_KEY, 1'b0);
    step(1);
    checkAll("unlock", 0, 0, 1, 0, 0, 8'd0);
    step(5);
    checkAll("unlock_ignore_key", 0, 0, 1, 0, 0, 8'd0);
    applyStimulus(1'b0, '0, 1'b0);
    step(4090);
    checkOutput("timeout_last/debug_unlocked", 32'(debug_unlocked), 32'd1);
    step(1);
    checkAll("timeout_exit", 1, 0, 0, 0, 0, 8'd0);

    // Three wrong keys lead to lockout
    sendKey(BAD_KEY);
    checkAll("fail1", 1, 0, 0, 2'd1, 0, 8'd0);
    sendKey(BAD_KEY);
    checkAll("fail2", 1, 0, 0, 2'd2, 0, 8'd0);
    sendKey(BAD_KEY);
    checkAll("lockout_enter", 0, 0, 0, 2'd3, 1, 8'd1);
    applyStimulus(1'b1, GOOD_KEY, 1'b1);
    step(1023);
    checkAll("lockout_last", 0, 0, 0, 2'd3, 1, 8'd1);
    applyStimulus(1'b0, '0, 1'b0);
    step(1);
    checkAll("lockout_exit", 1, 0, 0, 2'd0, 0, 8'd1);

    // Relock ten cycles into an unlock
    sendKey(GOOD_KEY);
    checkOutput("unlock2/debug_unlocked", 32'(debug_unlocked), 32'd1);
    step(9);
    checkOutput("pre_relock/debug_unlocked", 32'(debug_unlocked), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    step(1);
    checkAll("relock", 1, 0, 0, 2'd0, 0, 8'd1);
    step(1);
    checkAll("relock_idle_noop", 1, 0, 0, 2'd0, 0, 8'd1);
    applyStimulus(1'b0, '0, 1'b0);

    // Reset aborts an unlock and clears every counter
    sendKey(BAD_KEY);
    sendKey(BAD_KEY);
    checkOutput("pending/fail_cnt", 32'(fail_cnt), 32'd2);
    sendKey(GOOD_KEY);
    checkAll("unlock3", 0, 0, 1, 2'd0, 0, 8'd1);
    reset = 1'b1;
    step(1);
    checkAll("reset_abort", 0, 0, 0, 2'd0, 0, 8'd0);
    reset = 1'b0;
    step(1);
    checkAll("reset_release", 1, 1, 0, 2'd0, 0, 8'd0);
    step(1);
    checkOutput("reset_release/lock_drop", 32'(Lock), 32'd0);
    sendKey(GOOD_KEY);
    checkAll("unlock_after_reset", 0, 0, 1, 2'd0, 0, 8'd0);
    applyStimulus(1'b0, '0, 1'b1);
    step(1);
    applyStimulus(1'b0, '0, 1'b0);

    // All-zero fuse never matches, even against an all-zero key
    reset    = 1'b1;
    fuse_key = '0;
    step(1);
    reset = 1'b0;
    step(2);
    sendKey(16'h0000);
    checkAll("zero_fuse", 1, 0, 0, 2'd1, 0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
